// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a FIFO producer-consumer (master) and sync_fifo (slave).
// Status and response signals come back to the master; requests and write data go to the slave.
interface sync_fifo_if #(
  parameter int FIFO_WIDTH = 16
);
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, almostfull, empty, almostempty
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, almostfull, empty, almostempty
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: read data, wr_ack, overflow and underflow are registered (1 cycle after request).
// Status flags decode the count combinationally; writes while full and reads while empty are refused.
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_fifo_if.slave fifo_if
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALMOST_FULL_CNT = CW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty;
  logic wr_go, rd_go;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // Full implies non-empty (depth >= 4), so a simultaneous request while full is read-only.
  assign wr_go = fifo_if.wr_en && !full;
  assign rd_go = fifo_if.rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    wr_ack_d    = wr_go;
    overflow_d  = fifo_if.wr_en && full;
    underflow_d = fifo_if.rd_en && empty;

    if (wr_go) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_go) begin
      rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      data_out_d = mem[rd_ptr_q];
    end

    case ({wr_go, rd_go})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_ptr_q] <= fifo_if.data_in;
    end
  end

  assign fifo_if.data_out    = data_out_q;
  assign fifo_if.wr_ack      = wr_ack_q;
  assign fifo_if.overflow    = overflow_q;
  assign fifo_if.underflow   = underflow_q;
  assign fifo_if.full        = full;
  assign fifo_if.empty       = empty;
  assign fifo_if.almostfull  = (count_q == ALMOST_FULL_CNT);
  assign fifo_if.almostempty = (count_q == CW'(1));

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a queue-based reference model predicts every registered output and flag,
// and directed scenarios add fixed expectations for fill, overflow, drain, underflow, wrap and reset.
module tb_sync_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_if #(.FIFO_WIDTH(W)) fif ();

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fifo_if (fif)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents as a plain queue plus the last response values.
  logic [W-1:0] mq [$];
  logic [W-1:0] m_dout;
  logic         m_ack, m_ovf, m_udf;

  wire [W+6:0] obs_vec = {fif.data_out, fif.wr_ack, fif.overflow, fif.underflow,
                          fif.full, fif.almostfull, fif.empty, fif.almostempty};

  function automatic logic [W+6:0] exp_vec();
    int n;
    n = mq.size();
    return {m_dout, m_ack, m_ovf, m_udf, 1'(n == D), 1'(n == D - 1), 1'(n == 0), 1'(n == 1)};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_dout = '0;
    m_ack  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // One clock of requests: drive, let the edge pass, advance the model, return on negedge.
  task automatic step(input logic we, input logic re, input logic [W-1:0] din);
    int  n;
    logic wr_ok, rd_ok;
    fif.wr_en   = we;
    fif.rd_en   = re;
    fif.data_in = din;
    @(posedge clk);
    n     = mq.size();
    wr_ok = we && (n != D);
    rd_ok = re && (n != 0);
    if (rd_ok) m_dout = mq.pop_front();
    if (wr_ok) mq.push_back(din);
    m_ack = wr_ok;
    m_ovf = we && !wr_ok;
    m_udf = re && !rd_ok;
    @(negedge clk);
    fif.wr_en = 1'b0;
    fif.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    fif.wr_en   = 1'b0;
    fif.rd_en   = 1'b0;
    fif.data_in = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(16'h0100 + i));
    step(1'b0, 1'b1, '0);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_vec got %h want %h", obs_vec, exp_vec());
    end
    n_cmp++;
    if ({fif.data_out, fif.wr_ack, fif.overflow, fif.underflow, fif.empty} !== {16'h0000, 4'b0001}) begin
      n_err++;
      $display("FAIL reset_outs got dout=%h ack=%b ovf=%b udf=%b empty=%b want 0000/0/0/0/1",
               fif.data_out, fif.wr_ack, fif.overflow, fif.underflow, fif.empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      step(1'b1, 1'b0, W'(i));
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL fill_vec[%0d] got %h want %h", i, obs_vec, exp_vec());
      end
      n_cmp++;
      if ({fif.wr_ack, fif.almostfull, fif.full} !== {1'b1, 1'(i == 7), 1'(i == 8)}) begin
        n_err++;
        $display("FAIL fill_flags[%0d] got ack/af/full=%b%b%b want 1%b%b", i,
                 fif.wr_ack, fif.almostfull, fif.full, i == 7, i == 8);
      end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 16'hDEAD);
    n_cmp++;
    if (obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL ovf_vec got %h want %h", obs_vec, exp_vec());
    end
    n_cmp++;
    if ({fif.overflow, fif.wr_ack, fif.full} !== 3'b101) begin
      n_err++;
      $display("FAIL ovf_flags got ovf/ack/full=%b%b%b want 101", fif.overflow, fif.wr_ack, fif.full);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= D; i++) begin
      step(1'b0, 1'b1, '0);
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL drain_vec[%0d] got %h want %h", i, obs_vec, exp_vec());
      end
      n_cmp++;
      if ({fif.data_out, fif.almostempty, fif.empty} !== {W'(i), 1'(i == 7), 1'(i == 8)}) begin
        n_err++;
        $display("FAIL drain_data[%0d] got dout=%h ae=%b empty=%b want %h %b %b", i,
                 fif.data_out, fif.almostempty, fif.empty, W'(i), i == 7, i == 8);
      end
    end
  endtask

  task automatic test_underflow_simul();
    step(1'b0, 1'b1, '0);
    n_cmp++;
    if ({fif.underflow, fif.data_out, fif.empty} !== {1'b1, 16'h0008, 1'b1}) begin
      n_err++;
      $display("FAIL udf got udf=%b dout=%h empty=%b want 1 0008 1", fif.underflow, fif.data_out, fif.empty);
    end
    step(1'b1, 1'b1, 16'h1234);
    n_cmp++;
    if ({fif.wr_ack, fif.underflow, fif.almostempty, fif.empty, fif.data_out} !== {4'b1110, 16'h0008}) begin
      n_err++;
      $display("FAIL simul_empty got ack/udf/ae/empty=%b%b%b%b dout=%h want 1110 0008",
               fif.wr_ack, fif.underflow, fif.almostempty, fif.empty, fif.data_out);
    end
    for (int i = 0; i < D - 1; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL refill_vec[%0d] got %h want %h", i, obs_vec, exp_vec());
      end
    end
    step(1'b1, 1'b1, 16'hBEEF);
    n_cmp++;
    if ({fif.overflow, fif.wr_ack, fif.almostfull, fif.full, fif.data_out} !== {4'b1010, 16'h1234}) begin
      n_err++;
      $display("FAIL simul_full got ovf/ack/af/full=%b%b%b%b dout=%h want 1010 1234",
               fif.overflow, fif.wr_ack, fif.almostfull, fif.full, fif.data_out);
    end
    n_cmp++;
    if (obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL simul_full_vec got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_wrap_reset();
    logic [W-1:0] r;
    int p_wr;
    while (mq.size() != 0) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 20; i++) begin
      r = W'($urandom);
      step(1'b1, 1'b0, r);
      step(1'b0, 1'b1, '0);
      n_cmp++;
      if ({fif.data_out, fif.empty} !== {r, 1'b1}) begin
        n_err++;
        $display("FAIL wrap_pair[%0d] got dout=%h empty=%b want %h 1", i, fif.data_out, fif.empty, r);
      end
    end
    // Randomised traffic with drifting write bias so full and empty are both visited.
    for (int i = 0; i < 400; i++) begin
      p_wr = ((i / 50) % 2 == 0) ? 75 : 25;
      step(1'($urandom_range(0, 99) < p_wr), 1'($urandom_range(0, 99) < 100 - p_wr), W'($urandom));
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL rand_vec[%0d] got %h want %h", i, obs_vec, exp_vec());
      end
    end
    while (mq.size() != 0) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom));
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if ({fif.empty, fif.almostempty, fif.full, fif.almostfull} !== 4'b1000 || obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL midreset got %h want %h", obs_vec, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h00AA);
    step(1'b0, 1'b1, '0);
    n_cmp++;
    if ({fif.data_out, fif.empty} !== {16'h00AA, 1'b1}) begin
      n_err++;
      $display("FAIL post_reset got dout=%h empty=%b want 00aa 1", fif.data_out, fif.empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow_simul();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
